fifo_to_axis: RTL and testbench
===============================

FIFO_TO_AXIS -- requirements
Module: fifo_to_axis

Interface
REQ-001 SHALL provide parameter DW, default 32, data width in bits.
REQ-002 SHALL provide parameter BURST_LEN, default 16, beats per burst; legal range 2..256.
REQ-003 SHALL provide port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL provide port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL provide port en  input  1  drain enable; low blocks new FIFO reads.
REQ-006 SHALL provide port fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 SHALL provide port fifo_data  input  DW  upstream show-ahead head-of-FIFO data, valid whenever fifo_empty is low.
REQ-008 SHALL provide port fifo_rd_en  output  1  pop request to upstream FIFO.
REQ-009 SHALL provide port m_tvalid  output  1  stream beat valid.
REQ-010 SHALL provide port m_tready  input  1  downstream ready.
REQ-011 SHALL provide port m_tdata  output  DW  stream beat data.
REQ-012 SHALL provide port m_tlast  output  1  final beat of burst.
REQ-013 SHALL provide port beat_cnt  output  8  beats accepted in current burst.
REQ-014 SHALL provide port burst_done  output  1  one-cycle pulse per completed burst.

Function
REQ-015 SHALL hold a 2-entry in-order buffer; occupancy states EMPTY(0), ONE(1), TWO(2).
REQ-016 SHALL drive fifo_rd_en combinationally = en & ~fifo_empty & (state != TWO).
REQ-017 SHALL capture fifo_data into the buffer tail on the same clk edge where fifo_rd_en is high.
REQ-018 SHALL drive m_tvalid = (state != EMPTY) and m_tdata = buffer head, both from registers only.
REQ-019 SHALL pop the head on edges where m_tvalid & m_tready.
REQ-020 SHALL transition on push only: +1; pop only: -1; push and pop together: state unchanged, head advances, new entry at tail.
REQ-021 SHALL give latency of one cycle: FIFO non-empty in cycle N with state EMPTY -> m_tvalid high in N+1.
REQ-022 SHALL sustain one beat per cycle with m_tready held high and FIFO non-empty.
REQ-023 SHALL keep m_tdata, m_tlast stable while m_tvalid & ~m_tready.
REQ-024 SHALL increment beat_cnt on each accepted beat, wrapping to 0 after the beat where beat_cnt == BURST_LEN-1.
REQ-025 SHALL drive m_tlast = m_tvalid & (beat_cnt == BURST_LEN-1).
REQ-026 SHALL register burst_done high for exactly one cycle following acceptance of a beat with m_tlast high.
REQ-027 SHALL, with en low, issue no FIFO reads but continue draining buffered beats.
REQ-028 SHALL never assert fifo_rd_en when fifo_empty is high.

Reset
REQ-029 SHALL, on rst high, immediately set state EMPTY, beat_cnt 0, burst_done 0, m_tvalid 0, m_tlast 0, m_tdata 0.
REQ-030 SHALL discard buffered beats on reset mid-operation; the FIFO is not re-read for them.
REQ-031 SHALL hold fifo_rd_en low while rst is high.

Verification
REQ-032 SHALL cover: FIFO preloaded 0x1..0x4, en=1, m_tready=1 -> m_tdata 0x1,0x2,0x3,0x4 on consecutive cycles, first one cycle after en.
REQ-033 SHALL cover: m_tready=0 with FIFO non-empty -> exactly two pops, fifo_rd_en then low, m_tdata held at first word.
REQ-034 SHALL cover: BURST_LEN=4, 8 words streamed -> m_tlast on beats 4 and 8, burst_done pulses one cycle after each, beat_cnt back to 0.
REQ-035 SHALL cover: en dropped with state TWO -> two beats drain, no further fifo_rd_en.
REQ-036 SHALL cover: rst asserted mid-burst at beat_cnt=2 -> m_tvalid low same cycle, beat_cnt 0; next beat after release starts new burst.
REQ-037 SHALL cover: random m_tready and fifo_empty toggling, 10k cycles -> output order equals FIFO order, no loss, no duplication.

Source files
------------

// File: rtl/fifo_to_axis.sv
// Drains a show-ahead FIFO into an AXI-Stream master through a 2-entry skid buffer,
// grouping beats into fixed-length bursts with tlast and a burst-complete pulse.
module fifo_to_axis #(
    parameter int DW        = 32,
    parameter int BURST_LEN = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_rd_en,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tlast,
    output logic [7:0]    beat_cnt,
    output logic          burst_done
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

    state_t        state_q, state_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [7:0]    beat_cnt_q, beat_cnt_d;
    logic          burst_done_q, burst_done_d;
    logic          push, pop;

    // A full buffer never reads, so push and pop in TWO cannot coincide.
    assign fifo_rd_en = en & ~fifo_empty & (state_q != TWO) & ~rst;
    assign push       = fifo_rd_en;
    assign pop        = m_tvalid & m_tready;

    assign m_tvalid   = (state_q != EMPTY);
    assign m_tdata    = head_q;
    assign m_tlast    = m_tvalid & (beat_cnt_q == LAST_CNT);
    assign beat_cnt   = beat_cnt_q;
    assign burst_done = burst_done_q;

    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        beat_cnt_d   = beat_cnt_q;
        burst_done_d = 1'b0;

        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = fifo_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b11: head_d = fifo_data;
                    2'b10: begin
                        tail_d  = fifo_data;
                        state_d = TWO;
                    end
                    2'b01: state_d = EMPTY;
                    default: ;
                endcase
            end
            TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (pop) begin
            burst_done_d = m_tlast;
            beat_cnt_d   = (beat_cnt_q == LAST_CNT) ? 8'd0 : beat_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            head_q       <= '0;
            tail_q       <= '0;
            beat_cnt_q   <= 8'd0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            beat_cnt_q   <= beat_cnt_d;
            burst_done_q <= burst_done_d;
        end
    end

endmodule

// File: tb/tb_fifo_to_axis.sv
// Scoreboard bench for fifo_to_axis: a FIFO model feeds the DUT, a monitor checks
// every accepted beat, tlast, beat_cnt and burst_done against the expected stream.
module tb_fifo_to_axis;

    localparam int DW = 32;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst, en, fifo_empty, m_tready;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en, m_tvalid, m_tlast, burst_done;
    logic [DW-1:0] m_tdata;
    logic [7:0]    beat_cnt;

    fifo_to_axis #(.DW(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .beat_cnt(beat_cnt), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exq[$];
    bit  hold_empty = 1'b0;
    int  n_cmp = 0, n_err = 0;
    int  exp_beat = 0;
    bit  exp_done = 1'b0;
    int  inflight = 0, pop_cnt = 0, delivered = 0, n_last = 0, n_done = 0;
    bit  prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void refresh();
        fifo_empty = (fq.size() == 0) || hold_empty;
        fifo_data  = (fq.size() != 0) ? fq[0] : '0;
    endfunction

    task automatic load(input logic [DW-1:0] w);
        fq.push_back(w);
        exq.push_back(w);
        refresh();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 300 && (exq.size() != 0 || m_tvalid); k++) tick();
        chk("drain_in_time", 64'(k < 300), 64'd1);
    endtask

    // Upstream show-ahead FIFO: a read sampled before the edge pops just after it.
    always begin
        bit rd;
        @(negedge clk);
        rd = fifo_rd_en;
        if (rd) chk("rd_en_while_empty", 64'(fifo_empty), 64'd0);
        @(posedge clk);
        #1;
        if (rd) begin
            if (fq.size() == 0) chk("pop_from_empty", 64'(fq.size()), 64'd1);
            else void'(fq.pop_front());
            inflight++;
            pop_cnt++;
            refresh();
        end
    end

    // Monitor: values at the falling edge are what the next rising edge accepts.
    always begin
        logic [DW-1:0] w;
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("burst_done", 64'(burst_done), 64'(exp_done));
            if (burst_done) n_done++;
            exp_done = 1'b0;
            if (prev_stall) begin
                chk("stall_valid", 64'(m_tvalid), 64'd1);
                chk("stall_data", 64'(m_tdata), 64'(prev_data));
                chk("stall_last", 64'(m_tlast), 64'(prev_last));
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            if (m_tvalid && m_tready) begin
                if (exq.size() == 0) begin
                    chk("unexpected_beat", 64'(m_tdata), 64'hDEAD);
                end else begin
                    w = exq.pop_front();
                    chk("tdata", 64'(m_tdata), 64'(w));
                end
                chk("tlast", 64'(m_tlast), 64'(exp_beat == BL - 1));
                chk("beat_cnt", 64'(beat_cnt), 64'(exp_beat));
                if (m_tlast) n_last++;
                exp_done = (exp_beat == BL - 1);
                exp_beat = (exp_beat + 1) % BL;
                inflight--;
                delivered++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, d0, l0, dn0;
        rst = 1'b1; en = 1'b0; m_tready = 1'b0;
        refresh();

        // Reset state, with FIFO words waiting and en high
        #3;
        for (int i = 1; i <= 4; i++) load(DW'(i));
        en = 1'b1;
        #1;
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_tdata), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("rst_burst_done", 64'(burst_done), 64'd0);
        en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        m_tready = 1'b1;
        tick();

        // Preloaded 1..4 stream back-to-back, first beat one cycle after en
        en = 1'b1;
        chk("lat_tvalid_before", 64'(m_tvalid), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_tvalid", 64'(m_tvalid), 64'd1);
            chk("seq_tdata", 64'(m_tdata), 64'(i));
        end
        tick();
        chk("seq_tvalid_after", 64'(m_tvalid), 64'd0);
        tick();

        // Downstream stalled: exactly two pops, head held
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) load(32'h11 + DW'(i));
        p0 = pop_cnt;
        repeat (6) tick();
        chk("stall_pops", 64'(pop_cnt - p0), 64'd2);
        chk("stall_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("stall_head", 64'(m_tdata), 64'h11);
        m_tready = 1'b1;
        wait_drain();
        tick();

        // Two full bursts of four
        l0 = n_last; dn0 = n_done;
        for (int i = 0; i < 8; i++) load(32'h21 + DW'(i));
        wait_drain();
        tick();
        chk("burst_tlast_cnt", 64'(n_last - l0), 64'd2);
        chk("burst_done_cnt", 64'(n_done - dn0), 64'd2);
        chk("burst_beat_cnt_end", 64'(beat_cnt), 64'd0);

        // en dropped while full: two beats drain, no further reads
        m_tready = 1'b0;
        load(32'h31); load(32'h32); load(32'h33);
        p0 = pop_cnt;
        repeat (3) tick();
        chk("full_pops", 64'(pop_cnt - p0), 64'd2);
        en = 1'b0;
        m_tready = 1'b1;
        p0 = pop_cnt; d0 = delivered;
        repeat (4) tick();
        chk("en_low_no_reads", 64'(pop_cnt - p0), 64'd0);
        chk("en_low_drained", 64'(delivered - d0), 64'd2);
        chk("en_low_tvalid", 64'(m_tvalid), 64'd0);
        chk("mid_burst_cnt", 64'(beat_cnt), 64'd2);

        // Reset mid-burst with two beats buffered
        m_tready = 1'b0;
        load(32'h34);
        en = 1'b1;
        repeat (3) tick();
        chk("pre_rst_inflight", 64'(inflight), 64'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("mid_rst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        repeat (inflight) void'(exq.pop_front());
        inflight = 0; exp_beat = 0; exp_done = 1'b0;
        tick(); tick();
        load(32'h35);
        rst = 1'b0;
        m_tready = 1'b1;
        wait_drain();
        chk("post_rst_beat_cnt", 64'(beat_cnt), 64'd1);

        // Random ready and empty toggling
        for (int c = 0, nxt = 0; c < 10000; c++) begin
            while (fq.size() < 4) begin
                load(32'h1000 + DW'(nxt));
                nxt++;
            end
            hold_empty = ($urandom_range(0, 3) == 0);
            m_tready   = ($urandom_range(0, 2) != 0);
            refresh();
            tick();
        end
        hold_empty = 1'b0;
        m_tready = 1'b1;
        refresh();
        for (int k = 0; k < 300 && fq.size() != 0; k++) tick();
        wait_drain();
        chk("rand_fifo_empty", 64'(fq.size()), 64'd0);
        chk("rand_exp_empty", 64'(exq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
